// File: rtl/hc_mmio_csr_bank.sv
// HardCloud MMIO CSR bank: decodes CCI-P MMIO reads/writes into the DSM base, control FSM,
// NUM_BUFFERS buffer descriptors and a saturating run-cycle counter.

module hc_mmio_csr_desc (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_valid,
    input  logic        addr_we_lo,
    input  logic        addr_we_hi,
    input  logic        size_we,
    input  logic [31:0] wd_lo,
    input  logic [31:0] wd_hi,
    output logic [63:0] addr,
    output logic [31:0] size,
    output logic        valid
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr  <= '0;
            size  <= '0;
            valid <= 1'b0;
        end else begin
            if (addr_we_lo) addr[31:0]  <= wd_lo;
            if (addr_we_hi) addr[63:32] <= wd_hi;
            if (size_we)    size        <= wd_lo;
            if (clr_valid)    valid <= 1'b0;
            else if (size_we) valid <= 1'b1;
        end
    end
endmodule

module hc_mmio_csr_bank #(
    parameter int          NUM_BUFFERS = 2,
    parameter logic [15:0] BUF_BASE    = 16'h120,
    parameter logic [15:0] CTRL_ADDR   = 16'h118,
    parameter logic [15:0] DSM_ADDR    = 16'h110,
    parameter logic [15:0] CYC_ADDR    = 16'h108
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mmio_wr_valid,
    input  logic                        mmio_rd_valid,
    input  logic [15:0]                 mmio_addr,
    input  logic [1:0]                  mmio_len,
    input  logic [8:0]                  mmio_tid,
    input  logic [63:0]                 mmio_wdata,
    output logic                        mmio_rsp_valid,
    output logic [8:0]                  mmio_rsp_tid,
    output logic [63:0]                 mmio_rsp_data,
    output logic [63:0]                 dsm_base,
    output logic [64*NUM_BUFFERS-1:0]   buf_addr,
    output logic [32*NUM_BUFFERS-1:0]   buf_size,
    output logic [NUM_BUFFERS-1:0]      buf_valid,
    output logic                        acc_rst,
    output logic                        acc_start,
    output logic                        acc_stop,
    input  logic                        acc_done
);
    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Decode on qword index; the dword LSB picks the 32b half.
    localparam logic [14:0] DSM_Q  = {2'b0, DSM_ADDR[15:3]};
    localparam logic [14:0] CTRL_Q = {2'b0, CTRL_ADDR[15:3]};
    localparam logic [14:0] CYC_Q  = {2'b0, CYC_ADDR[15:3]};
    localparam logic [14:0] BUF_Q  = {2'b0, BUF_BASE[15:3]};

    logic [1:0]  state, state_d;
    logic [63:0] cyc;
    logic        done_q, start_d, stop_d, cyc_clr, clr_valid;
    logic [14:0] q, buf_off;
    logic        odd, is8, wr_ok, wr_lo, wr_hi, unlocked, buf_hit, buf_is_size, ctrl_wr;
    logic [3:0]  buf_idx;
    logic [31:0] wd_lo, wd_hi, cv;
    logic [63:0] rd_reg, rd_data;

    assign q        = mmio_addr[15:1];
    assign odd      = mmio_addr[0];
    assign is8      = (mmio_len == 2'd1);
    assign wr_ok    = mmio_wr_valid && !mmio_len[1];
    assign wr_lo    = wr_ok && !odd;
    assign wr_hi    = wr_ok && (is8 ? !odd : odd);
    assign wd_lo    = mmio_wdata[31:0];
    assign wd_hi    = is8 ? mmio_wdata[63:32] : mmio_wdata[31:0];
    assign unlocked = (state != S_RUN);

    assign buf_off     = q - BUF_Q;
    assign buf_hit     = (q >= BUF_Q) && (buf_off < 15'(2*NUM_BUFFERS));
    assign buf_idx     = buf_off[4:1];
    assign buf_is_size = buf_off[0];

    assign ctrl_wr = wr_lo && (q == CTRL_Q);
    assign cv      = mmio_wdata[31:0];
    assign acc_rst = (state == S_RESET);

    always_comb begin
        state_d   = state;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        cyc_clr   = 1'b0;
        clr_valid = 1'b0;
        if (ctrl_wr && cv == 32'd0) begin
            state_d   = S_RESET;
            cyc_clr   = 1'b1;
            clr_valid = 1'b1;
        end else if (ctrl_wr && cv == 32'd1 && state == S_RESET) begin
            state_d = S_IDLE;
        end else if (ctrl_wr && cv == 32'd3 && (state == S_IDLE || state == S_STOP)) begin
            state_d = S_RUN;
            start_d = 1'b1;
            cyc_clr = 1'b1;
        end else if (state == S_RUN && ((ctrl_wr && cv == 32'd7) || (acc_done && !done_q))) begin
            state_d = S_STOP;
            stop_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RESET;
            done_q    <= 1'b0;
            acc_start <= 1'b0;
            acc_stop  <= 1'b0;
            cyc       <= '0;
            dsm_base  <= '0;
        end else begin
            state     <= state_d;
            done_q    <= acc_done;
            acc_start <= start_d;
            acc_stop  <= stop_d;
            if (cyc_clr)                       cyc <= '0;
            else if (state == S_RUN && ~&cyc)  cyc <= cyc + 64'd1;
            if (unlocked && wr_lo && q == DSM_Q) dsm_base[31:0]  <= wd_lo;
            if (unlocked && wr_hi && q == DSM_Q) dsm_base[63:32] <= wd_hi;
        end
    end

    for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_desc
        logic sel;
        assign sel = unlocked && buf_hit && (buf_idx == 4'(i));
        hc_mmio_csr_desc u_desc (
            .clk        (clk),
            .reset      (reset),
            .clr_valid  (clr_valid),
            .addr_we_lo (sel && !buf_is_size && wr_lo),
            .addr_we_hi (sel && !buf_is_size && wr_hi),
            .size_we    (sel && buf_is_size && wr_lo),
            .wd_lo      (wd_lo),
            .wd_hi      (wd_hi),
            .addr       (buf_addr[64*i +: 64]),
            .size       (buf_size[32*i +: 32]),
            .valid      (buf_valid[i])
        );
    end

    // Read mux sees pre-write register values, so a same-cycle write does not leak into the response.
    always_comb begin
        rd_reg = '0;
        if (q == DSM_Q)       rd_reg = dsm_base;
        else if (q == CTRL_Q) rd_reg = {61'b0, state, acc_done};
        else if (q == CYC_Q)  rd_reg = cyc;
        else if (buf_hit) begin
            for (int i = 0; i < NUM_BUFFERS; i++)
                if (buf_idx == 4'(i))
                    rd_reg = buf_is_size ? {32'b0, buf_size[32*i +: 32]} : buf_addr[64*i +: 64];
        end
        case (mmio_len)
            2'd0:    rd_data = odd ? {32'b0, rd_reg[63:32]} : {32'b0, rd_reg[31:0]};
            2'd1:    rd_data = odd ? 64'd0 : rd_reg;
            default: rd_data = 64'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_rsp_valid <= 1'b0;
            mmio_rsp_tid   <= '0;
            mmio_rsp_data  <= '0;
        end else begin
            mmio_rsp_valid <= mmio_rd_valid;
            mmio_rsp_tid   <= mmio_rd_valid ? mmio_tid : 9'd0;
            mmio_rsp_data  <= mmio_rd_valid ? rd_data : 64'd0;
        end
    end
endmodule

// File: tb/tb_hc_mmio_csr_bank.sv
// Directed bench for hc_mmio_csr_bank (NUM_BUFFERS=4): decode, read-back, lock, FSM and counter.

module tb_hc_mmio_csr_bank;
    logic         clk, reset;
    logic         mmio_wr_valid, mmio_rd_valid;
    logic [15:0]  mmio_addr;
    logic [1:0]   mmio_len;
    logic [8:0]   mmio_tid;
    logic [63:0]  mmio_wdata;
    logic         mmio_rsp_valid;
    logic [8:0]   mmio_rsp_tid;
    logic [63:0]  mmio_rsp_data;
    logic [63:0]  dsm_base;
    logic [255:0] buf_addr;
    logic [127:0] buf_size;
    logic [3:0]   buf_valid;
    logic         acc_rst, acc_start, acc_stop, acc_done;

    int tests = 0;
    int fails = 0;

    hc_mmio_csr_bank #(.NUM_BUFFERS(4)) dut (
        .clk(clk), .reset(reset),
        .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr(mmio_addr), .mmio_len(mmio_len), .mmio_tid(mmio_tid),
        .mmio_wdata(mmio_wdata),
        .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid),
        .mmio_rsp_data(mmio_rsp_data),
        .dsm_base(dsm_base), .buf_addr(buf_addr), .buf_size(buf_size),
        .buf_valid(buf_valid), .acc_rst(acc_rst), .acc_start(acc_start),
        .acc_stop(acc_stop), .acc_done(acc_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one strobe cycle and returns at the next negedge.
    task automatic xact(input logic wr, input logic rd, input logic [15:0] ba,
                        input logic [1:0] len, input logic [8:0] tid, input logic [63:0] wd);
        mmio_wr_valid = wr;
        mmio_rd_valid = rd;
        mmio_addr     = {2'b0, ba[15:2]};
        mmio_len      = len;
        mmio_tid      = tid;
        mmio_wdata    = wd;
        @(negedge clk);
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
    endtask

    initial begin
        clk = 0; reset = 1; acc_done = 0;
        mmio_wr_valid = 0; mmio_rd_valid = 0; mmio_addr = 0;
        mmio_len = 0; mmio_tid = 0; mmio_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_acc_rst", acc_rst, 1);
        chk("rst_dsm", dsm_base, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_buf_size", buf_size, 0);
        chk("rst_misc", {buf_valid, mmio_rsp_valid, acc_start, acc_stop}, 0);
        reset = 0;

        // descriptor 0 address write then read-back
        xact(1, 0, 16'h120, 2'd1, 0, 64'h1000);
        chk("buf0_addr", buf_addr, 256'h1000);
        xact(0, 1, 16'h120, 2'd1, 9'd5, 0);
        chk("rd_valid", mmio_rsp_valid, 1);
        chk("rd_tid", mmio_rsp_tid, 5);
        chk("rd_data", mmio_rsp_data, 64'h1000);
        @(negedge clk);
        chk("rd_valid_drop", mmio_rsp_valid, 0);

        // descriptor 3 size (only low 32b taken), out-of-range index ignored
        xact(1, 0, 16'h158, 2'd1, 0, 64'hFFFF_FFFF_0000_0040);
        chk("buf3_size", buf_size, {32'h40, 96'h0});
        chk("buf_valid3", buf_valid, 4'b1000);
        xact(1, 0, 16'h168, 2'd1, 0, 64'h1234);
        chk("oob_addr", buf_addr, 256'h1000);
        chk("oob_size", buf_size, {32'h40, 96'h0});
        xact(0, 1, 16'h168, 2'd1, 9'd7, 0);
        chk("oob_rd", {mmio_rsp_valid, mmio_rsp_data}, {1'b1, 64'h0});

        // DSM: 8B then 4B to the odd dword
        xact(1, 0, 16'h110, 2'd1, 0, 64'h1111_2222_3333_4444);
        xact(1, 0, 16'h114, 2'd0, 0, 64'hAAAA_BBBB);
        chk("dsm_hi4", dsm_base, 64'hAAAA_BBBB_3333_4444);
        xact(0, 1, 16'h114, 2'd0, 9'd1, 0);
        chk("dsm_rd_hi", mmio_rsp_data, 64'hAAAA_BBBB);
        xact(0, 1, 16'h110, 2'd0, 9'd2, 0);
        chk("dsm_rd_lo", mmio_rsp_data, 64'h3333_4444);

        // control FSM
        xact(0, 1, 16'h118, 2'd1, 0, 0);
        chk("ctrl_reset", mmio_rsp_data, 0);
        xact(1, 0, 16'h118, 2'd0, 0, 64'd1);
        chk("idle_acc_rst", acc_rst, 0);
        xact(0, 1, 16'h118, 2'd1, 0, 0);
        chk("ctrl_idle", mmio_rsp_data, 64'd2);
        xact(1, 0, 16'h118, 2'd0, 0, 64'd3);
        chk("start_pulse", acc_start, 1);
        @(negedge clk);
        chk("start_clear", acc_start, 0);
        repeat (9) @(negedge clk);
        xact(0, 1, 16'h108, 2'd1, 9'd3, 0);
        chk("cyc_10", mmio_rsp_data, 64'd10);
        xact(1, 0, 16'h120, 2'd1, 0, 64'hDEAD);
        chk("lock_addr", buf_addr, 256'h1000);
        xact(1, 0, 16'h118, 2'd0, 0, 64'd7);
        chk("stop_pulse", acc_stop, 1);
        @(negedge clk);
        chk("stop_clear", acc_stop, 0);
        xact(0, 1, 16'h108, 2'd1, 0, 0);
        chk("cyc_hold", mmio_rsp_data, 64'd13);
        xact(0, 1, 16'h118, 2'd1, 0, 0);
        chk("ctrl_stop", mmio_rsp_data, 64'd6);
        xact(1, 0, 16'h120, 2'd1, 0, 64'hDEAD);
        chk("unlock_addr", buf_addr, 256'hDEAD);

        // same-cycle read and write
        xact(1, 1, 16'h110, 2'd1, 9'd9, 64'h5555);
        chk("rw_old", mmio_rsp_data, 64'hAAAA_BBBB_3333_4444);
        chk("rw_new", dsm_base, 64'h5555);

        // restart clears counter; acc_done rise stops
        xact(1, 0, 16'h118, 2'd0, 0, 64'd3);
        acc_done = 1;
        @(negedge clk);
        chk("done_stop", acc_stop, 1);
        xact(0, 1, 16'h118, 2'd1, 0, 0);
        chk("ctrl_done", mmio_rsp_data, 64'd7);
        xact(0, 1, 16'h108, 2'd1, 0, 0);
        chk("cyc_restart", mmio_rsp_data, 64'd1);
        acc_done = 0;
        xact(1, 0, 16'h118, 2'd0, 0, 64'd0);
        chk("sreset_valid", buf_valid, 0);
        chk("sreset_acc_rst", acc_rst, 1);
        xact(0, 1, 16'h108, 2'd1, 0, 0);
        chk("sreset_cyc", mmio_rsp_data, 0);

        // locked size write leaves valid clear
        xact(1, 0, 16'h118, 2'd0, 0, 64'd1);
        xact(1, 0, 16'h118, 2'd0, 0, 64'd3);
        xact(1, 0, 16'h128, 2'd1, 0, 64'h80);
        chk("lock_size", {buf_valid, buf_size[31:0]}, 0);

        // async reset drops the pending response
        mmio_rd_valid = 1;
        mmio_addr     = 16'h48;
        mmio_len      = 2'd1;
        @(posedge clk);
        #1 reset = 1;
        mmio_rd_valid = 0;
        #1 chk("rst_rsp_drop", mmio_rsp_valid, 0);
        @(negedge clk);
        chk("rst_mid_acc_rst", acc_rst, 1);
        chk("rst_mid_outs", {dsm_base, buf_valid, acc_start, acc_stop}, 0);
        chk("rst_mid_buf", buf_addr, 0);
        reset = 0;
        @(negedge clk);
        chk("rst_mid_norsp", mmio_rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
